// File: rtl/stream_sink_pkg.sv
// stream_sink_pkg: shared modes, LFSR taps and saturating increment for the stream sink.
package stream_sink_pkg;
  localparam logic [1:0] MODE_ALWAYS   = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;
  localparam logic [1:0] MODE_RANDOM   = 2'd2;
  localparam logic [1:0] MODE_PAUSE    = 2'd3;
  // Fibonacci taps for x^16+x^14+x^13+x^11+1 in a right-shifting register
  localparam logic [15:0] LFSR_TAPS = 16'h002D;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v == max) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/bp_pattern_gen.sv
// bp_pattern_gen: registered s_ready backpressure pattern (always, periodic, random, pause).
module bp_pattern_gen import stream_sink_pkg::*; #(
  parameter int          PERIOD_W  = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic [PERIOD_W-1:0] period,
  input  logic [PERIOD_W-1:0] on_cycles,
  output logic                s_ready
);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'd0) ? 16'h0001 : LFSR_SEED;
  logic [PERIOD_W-1:0] phase_q, phase_d, eff_period;
  logic [15:0] lfsr_q, lfsr_d;
  logic ready_q, ready_d;
  always_comb begin
    eff_period = (period == '0) ? PERIOD_W'(1) : period;
    phase_d = (mode != MODE_PERIODIC || phase_q >= eff_period - PERIOD_W'(1)) ? '0 : phase_q + PERIOD_W'(1);
    lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
    ready_d = (mode == MODE_ALWAYS)   ? 1'b1 :
              (mode == MODE_PERIODIC) ? (phase_q < on_cycles) :
              (mode == MODE_RANDOM)   ? lfsr_q[0] : 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      lfsr_q  <= SEED;
      ready_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      lfsr_q  <= lfsr_d;
      ready_q <= ready_d;
    end
  end
  assign s_ready = ready_q;
endmodule

// File: rtl/stream_sink_bp.sv
// stream_sink_bp: backpressuring stream sink with beat mirror, saturating counters
// and sticky upstream handshake-violation flags.
module stream_sink_bp import stream_sink_pkg::*; #(
  parameter int          DATA_W    = 8,
  parameter int          CNT_W     = 16,
  parameter int          PERIOD_W  = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  input  logic                s_last,
  input  logic [DATA_W-1:0]   s_data,
  output logic                s_ready,
  input  logic [1:0]          mode,
  input  logic [PERIOD_W-1:0] period,
  input  logic [PERIOD_W-1:0] on_cycles,
  input  logic                clear,
  output logic                m_valid,
  output logic                m_last,
  output logic [DATA_W-1:0]   m_data,
  output logic [CNT_W-1:0]    beat_count,
  output logic [CNT_W-1:0]    pkt_count,
  output logic                err_drop,
  output logic                err_change
);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
  logic xfer;
  logic stall_q, stall_d, cap_last_q, cap_last_d;
  logic [DATA_W-1:0] cap_data_q, cap_data_d, m_data_q, m_data_d;
  logic m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [CNT_W-1:0] beat_q, beat_d, pkt_q, pkt_d;
  logic err_drop_q, err_drop_d, err_change_q, err_change_d;
  bp_pattern_gen #(.PERIOD_W(PERIOD_W), .LFSR_SEED(LFSR_SEED)) u_bp (
    .clk(clk), .rst_n(rst_n), .mode(mode), .period(period), .on_cycles(on_cycles), .s_ready(s_ready)
  );
  always_comb begin
    xfer = s_valid && s_ready;
    stall_d = s_valid && !s_ready;
    cap_data_d = s_data;
    cap_last_d = s_last;
    m_valid_d = xfer;
    m_last_d = xfer && s_last;
    m_data_d = xfer ? s_data : m_data_q;
    beat_d = clear ? '0 : xfer ? CNT_W'(sat_inc(32'(beat_q), CNT_MAX)) : beat_q;
    pkt_d = clear ? '0 : (xfer && s_last) ? CNT_W'(sat_inc(32'(pkt_q), CNT_MAX)) : pkt_q;
    // the capture is only meaningful in the cycle after a stall
    err_drop_d = !clear && (err_drop_q || (stall_q && !s_valid));
    err_change_d = !clear && (err_change_q ||
                   (stall_q && s_valid && (s_data != cap_data_q || s_last != cap_last_q)));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q      <= 1'b0;
      cap_last_q   <= 1'b0;
      cap_data_q   <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_data_q     <= '0;
      beat_q       <= '0;
      pkt_q        <= '0;
      err_drop_q   <= 1'b0;
      err_change_q <= 1'b0;
    end else begin
      stall_q      <= stall_d;
      cap_last_q   <= cap_last_d;
      cap_data_q   <= cap_data_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      m_data_q     <= m_data_d;
      beat_q       <= beat_d;
      pkt_q        <= pkt_d;
      err_drop_q   <= err_drop_d;
      err_change_q <= err_change_d;
    end
  end
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign m_data     = m_data_q;
  assign beat_count = beat_q;
  assign pkt_count  = pkt_q;
  assign err_drop   = err_drop_q;
  assign err_change = err_change_q;
endmodule

// File: tb/tb_stream_sink_bp.sv
// tb_stream_sink_bp: table-driven ready-pattern vectors plus a mirror scoreboard
// and hand-written sequences for counters, protocol errors, LFSR and reset.
module tb_stream_sink_bp;
  logic clk = 1'b0, rst_n = 1'b0;
  logic s_valid = 1'b0, s_last = 1'b0, clear = 1'b0;
  logic [7:0] s_data = '0;
  logic [1:0] mode = 2'd1;
  logic [3:0] period = 4'd4, on_cycles = 4'd1;
  logic s_ready, m_valid, m_last, err_drop, err_change;
  logic [7:0] m_data;
  logic [3:0] beat_count, pkt_count;

  typedef struct {logic [1:0] mode; logic [3:0] period; logic [3:0] on; logic exp_ready;} vec_t;
  typedef struct {logic [7:0] data; logic last;} beat_t;
  vec_t vecs[$];
  beat_t sb[$];
  int checks = 0, passed = 0;
  logic [7:0] next_data = 8'd0;
  logic [15:0] lfsr_m;
  logic xf;

  always #5 clk = ~clk;

  stream_sink_bp #(.DATA_W(8), .CNT_W(4), .PERIOD_W(4), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_last(s_last), .s_data(s_data),
    .s_ready(s_ready), .mode(mode), .period(period), .on_cycles(on_cycles), .clear(clear),
    .m_valid(m_valid), .m_last(m_last), .m_data(m_data), .beat_count(beat_count),
    .pkt_count(pkt_count), .err_drop(err_drop), .err_change(err_change)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic add(input logic [1:0] m, input logic [3:0] p, input logic [3:0] o, input logic r);
    vec_t v;
    v.mode = m; v.period = p; v.on = o; v.exp_ready = r;
    vecs.push_back(v);
  endtask

  // one clock: record a transfer if the handshake fires, then score the mirror
  task automatic cyc(output logic x);
    beat_t b;
    x = s_valid && s_ready;
    if (x) begin
      b.data = s_data; b.last = s_last;
      sb.push_back(b);
    end
    @(posedge clk); #1;
    check("m_valid", m_valid, sb.size() != 0);
    if (m_valid && sb.size() != 0) begin
      b = sb.pop_front();
      check("m_data", m_data, b.data);
      check("m_last", m_last, b.last);
    end else begin
      check("m_last_idle", m_last, 0);
      sb.delete();
    end
  endtask

  task automatic lfsr_step();
    lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
  endtask

  initial begin
    for (int i = 0; i < 20; i++) add(2'd1, 4'd4, 4'd1, (i % 4) == 0);
    add(2'd1, 4'd8, 4'd4, 1); add(2'd1, 4'd8, 4'd4, 1); add(2'd1, 4'd8, 4'd4, 1);
    add(2'd1, 4'd8, 4'd4, 1); add(2'd1, 4'd8, 4'd4, 0); add(2'd1, 4'd8, 4'd4, 0);
    add(2'd1, 4'd3, 4'd1, 0); add(2'd1, 4'd3, 4'd1, 1); add(2'd1, 4'd3, 4'd1, 0);
    add(2'd1, 4'd3, 4'd1, 0); add(2'd1, 4'd3, 4'd1, 1);
    for (int i = 0; i < 6; i++) add(2'd1, 4'd3, 4'd0, 0);
    add(2'd1, 4'd0, 4'd1, 0); add(2'd1, 4'd0, 4'd1, 1); add(2'd1, 4'd0, 4'd1, 1); add(2'd1, 4'd0, 4'd1, 1);

    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_beat", beat_count, 0);
    check("rst_pkt", pkt_count, 0);
    check("rst_err_drop", err_drop, 0);
    check("rst_err_change", err_change, 0);
    rst_n = 1'b1;

    s_valid = 1'b1;
    foreach (vecs[i]) begin
      mode = vecs[i].mode; period = vecs[i].period; on_cycles = vecs[i].on;
      s_data = next_data; s_last = 1'b0;
      cyc(xf);
      if (xf) next_data++;
      check($sformatf("ready_vec%0d", i), s_ready, vecs[i].exp_ready);
      if (i == 19) check("periodic_beats", beat_count, 5);
    end
    check("periodic_err_drop", err_drop, 0);
    check("periodic_err_change", err_change, 0);

    mode = 2'd0; clear = 1'b1; s_data = next_data;
    cyc(xf);
    if (xf) next_data++;
    clear = 1'b0;
    check("clear_xfer_beat", beat_count, 0);
    check("clear_pkt", pkt_count, 0);
    s_valid = 1'b0;
    cyc(xf);

    s_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      s_data = next_data; s_last = (i % 3) == 0;
      cyc(xf);
      if (xf) next_data++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    cyc(xf);
    check("pkt_beats", beat_count, 6);
    check("pkt_count", pkt_count, 2);
    check("pkt_err_drop", err_drop, 0);
    check("pkt_err_change", err_change, 0);

    clear = 1'b1;
    cyc(xf);
    clear = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_data = next_data;
      cyc(xf);
      if (xf) next_data++;
    end
    check("sat_beat", beat_count, 15);
    clear = 1'b1; s_data = next_data;
    cyc(xf);
    if (xf) next_data++;
    check("clear_wins_beat", beat_count, 0);
    clear = 1'b0; s_data = next_data;
    cyc(xf);
    if (xf) next_data++;
    check("after_clear_beat", beat_count, 1);
    s_valid = 1'b0;
    cyc(xf);

    mode = 2'd3;
    cyc(xf);
    check("pause_ready", s_ready, 0);
    s_valid = 1'b1; s_data = 8'h5A;
    repeat (3) cyc(xf);
    check("stable_err_change", err_change, 0);
    check("stable_err_drop", err_drop, 0);
    s_data = 8'h5B;
    cyc(xf);
    check("change_err_change", err_change, 1);
    check("change_err_drop", err_drop, 0);
    clear = 1'b1; s_valid = 1'b0;
    cyc(xf);
    clear = 1'b0;
    check("clear_err_drop", err_drop, 0);
    check("clear_err_change", err_change, 0);
    cyc(xf);
    s_valid = 1'b1; s_data = 8'h5A;
    repeat (2) cyc(xf);
    s_valid = 1'b0;
    cyc(xf);
    check("drop_err_drop", err_drop, 1);
    check("drop_err_change", err_change, 0);

    for (int pass = 0; pass < 2; pass++) begin
      rst_n = 1'b0; mode = 2'd2; s_valid = 1'b1; s_data = next_data;
      #2;
      check("async_rst_ready", s_ready, 0);
      check("async_rst_beat", beat_count, 0);
      check("async_rst_m_valid", m_valid, 0);
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      lfsr_m = 16'hACE1;
      for (int i = 0; i < 64; i++) begin
        logic exp_r;
        exp_r = lfsr_m[0];
        lfsr_step();
        s_data = next_data;
        cyc(xf);
        if (xf) next_data++;
        check($sformatf("lfsr_ready_p%0d_c%0d", pass, i), s_ready, exp_r);
      end
      check("lfsr_err_drop", err_drop, 0);
      check("lfsr_err_change", err_change, 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
